// File: rtl/ahb_bus_arbiter.sv
// AHB bus arbiter: round-robin grant of the shared address/data bus with
// fixed-length burst protection, undefined-length INCR hold, locked-sequence
// hold and default-master parking. Grant is registered; the address-phase
// owner (hmaster) follows one hready cycle later and the data-phase owner
// (hmasterData) one further hready cycle after that.
`timescale 1ns/1ps

module ahb_bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int HMASTER_WIDTH  = (NUM_MASTERS == 1) ? 1 : $clog2(NUM_MASTERS),
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                     hclk,
  input  logic                     hreset,
  input  logic [NUM_MASTERS-1:0]   hbusreq,
  input  logic [NUM_MASTERS-1:0]   hlock,
  input  logic [1:0]               htrans,
  input  logic [2:0]               hburst,
  input  logic                     hready,
  output logic [NUM_MASTERS-1:0]   hgrant,
  output logic [HMASTER_WIDTH-1:0] hmaster,
  output logic [HMASTER_WIDTH-1:0] hmasterData,
  output logic                     hmastlock
);

  typedef enum logic [1:0] {
    ST_PARK   = 2'd0,
    ST_OWNED  = 2'd1,
    ST_BURST  = 2'd2,
    ST_LOCKED = 2'd3
  } state_e;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  localparam logic [HMASTER_WIDTH-1:0] DEF_ID    = HMASTER_WIDTH'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0]   DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

  // Beats in a fixed-length burst; SINGLE and INCR are not counted.
  function automatic logic [4:0] burst_len(input logic [2:0] b);
    case (b)
      3'b010, 3'b011: burst_len = 5'd4;
      3'b100, 3'b101: burst_len = 5'd8;
      3'b110, 3'b111: burst_len = 5'd16;
      default:        burst_len = 5'd0;
    endcase
  endfunction

  state_e                   state_q, state_d;
  logic [3:0]               beats_q, beats_d;
  logic [HMASTER_WIDTH-1:0] rr_q, rr_d;
  logic [HMASTER_WIDTH-1:0] grant_id_q, grant_id_d;
  logic [NUM_MASTERS-1:0]   hgrant_q, hgrant_d;
  logic [HMASTER_WIDTH-1:0] hmaster_q, hmaster_d;
  logic [HMASTER_WIDTH-1:0] hmaster_data_q, hmaster_data_d;
  logic                     hmastlock_q, hmastlock_d;

  logic [4:0]               len;
  logic [4:0]               len_m1;
  logic                     acc_ns, acc_seq, addr_free;
  logic                     owner_req, owner_lock;
  logic                     handover, step;
  logic                     start_lock, start_burst;
  logic                     arb_ok;
  logic                     rr_found;
  logic [HMASTER_WIDTH-1:0] rr_winner;

  assign len         = burst_len(hburst);
  assign len_m1      = len - 5'd1;
  assign acc_ns      = hready && (htrans == TR_NONSEQ);
  assign acc_seq     = hready && (htrans == TR_SEQ);
  assign addr_free   = (htrans == TR_IDLE) || (htrans == TR_NONSEQ);
  assign owner_req   = hbusreq[hmaster_q];
  assign owner_lock  = hlock[hmaster_q];
  // While the new grantee has not yet taken the address phase, htrans still
  // belongs to the outgoing owner, so neither arbitration nor counting runs.
  assign handover    = (grant_id_q != hmaster_q);
  assign step        = hready && !handover;
  assign start_lock  = acc_ns && owner_lock;
  assign start_burst = acc_ns && (len != 5'd0);

  // Round-robin search from rr_q+1; the last winner comes up last.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    rr_found  = 1'b0;
    rr_winner = DEF_ID;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      if (!rr_found && hbusreq[(int'(rr_q) + i) % NUM_MASTERS]) begin
        rr_found  = 1'b1;
        rr_winner = HMASTER_WIDTH'((int'(rr_q) + i) % NUM_MASTERS);
      end
    end
  end

  // Decide whether the bus may be handed on at this edge.
  always_comb begin
    arb_ok = 1'b0;
    case (state_q)
      ST_PARK:   arb_ok = step && !start_lock && !start_burst;
      ST_OWNED:  arb_ok = step && !start_lock && !start_burst &&
                          (addr_free || !owner_req);
      ST_BURST:  arb_ok = step && acc_seq && (beats_q == 4'd1);
      ST_LOCKED: arb_ok = step && !owner_lock && addr_free &&
                          (beats_q == 4'd0) && !start_burst;
      default:   arb_ok = 1'b0;
    endcase
  end

  // Next-state, beat counter, grant and owner tracking.
  always_comb begin
    state_d        = state_q;
    beats_d        = beats_q;
    rr_d           = rr_q;
    grant_id_d     = grant_id_q;
    hgrant_d       = hgrant_q;
    hmaster_d      = hmaster_q;
    hmaster_data_d = hmaster_data_q;

    if (hready) begin
      hmaster_d      = grant_id_q;
      hmaster_data_d = hmaster_q;
    end

    if (step) begin
      if (start_burst) begin
        beats_d = len_m1[3:0];
      end else if (acc_seq && (beats_q != 4'd0)) begin
        beats_d = beats_q - 4'd1;
      end

      if (arb_ok) begin
        if (rr_found) begin
          grant_id_d = rr_winner;
          hgrant_d   = NUM_MASTERS'(1) << rr_winner;
          rr_d       = rr_winner;
          state_d    = ST_OWNED;
        end else begin
          grant_id_d = DEF_ID;
          hgrant_d   = DEF_GRANT;
          state_d    = ST_PARK;
        end
      end else if (start_lock) begin
        state_d = ST_LOCKED;
      end else if (start_burst) begin
        state_d = ST_BURST;
      end
    end

    hmastlock_d = (state_d == ST_LOCKED);
  end

  // State registers with asynchronous reset to the parked default master.
  always_ff @(posedge hclk or posedge hreset) begin
    // NOTE: all state is reset here because the reset values are visible
    // bus outputs; sequential state uses non-blocking assignment only.
    if (hreset) begin
      state_q        <= ST_PARK;
      beats_q        <= 4'd0;
      rr_q           <= DEF_ID;
      grant_id_q     <= DEF_ID;
      hgrant_q       <= DEF_GRANT;
      hmaster_q      <= DEF_ID;
      hmaster_data_q <= DEF_ID;
      hmastlock_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      beats_q        <= beats_d;
      rr_q           <= rr_d;
      grant_id_q     <= grant_id_d;
      hgrant_q       <= hgrant_d;
      hmaster_q      <= hmaster_d;
      hmaster_data_q <= hmaster_data_d;
      hmastlock_q    <= hmastlock_d;
    end
  end

  assign hgrant      = hgrant_q;
  assign hmaster     = hmaster_q;
  assign hmasterData = hmaster_data_q;
  assign hmastlock   = hmastlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter (4 managers, default master 0).
// Each step drives one cycle of inputs, queues the outputs expected after
// the next rising edge, then pops and compares them 1 ns after that edge.
`timescale 1ns/1ps

module tb_ahb_bus_arbiter;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000;
  localparam logic [2:0] INCR8  = 3'b101;
  localparam logic [2:0] INCR16 = 3'b111;

  logic       hclk;
  logic       hreset;
  logic [3:0] hbusreq;
  logic [3:0] hlock;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic       hready;
  logic [3:0] hgrant;
  logic [1:0] hmaster;
  logic [1:0] hmasterData;
  logic       hmastlock;

  typedef struct {
    string      tag;
    logic [3:0] g;
    logic [1:0] m;
    logic [1:0] d;
    logic       l;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  ahb_bus_arbiter #(
    .NUM_MASTERS   (4),
    .DEFAULT_MASTER(0)
  ) dut (
    .hclk       (hclk),
    .hreset     (hreset),
    .hbusreq    (hbusreq),
    .hlock      (hlock),
    .htrans     (htrans),
    .hburst     (hburst),
    .hready     (hready),
    .hgrant     (hgrant),
    .hmaster    (hmaster),
    .hmasterData(hmasterData),
    .hmastlock  (hmastlock)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [3:0] g, input logic [1:0] m,
                               input logic [1:0] d, input logic l);
    check({tag, ".hgrant"},      32'(hgrant),      32'(g));
    check({tag, ".hmaster"},     32'(hmaster),     32'(m));
    check({tag, ".hmasterData"}, 32'(hmasterData), 32'(d));
    check({tag, ".hmastlock"},   32'(hmastlock),   32'(l));
  endtask

  // Drive one cycle, queue the expectation, compare after the edge.
  task automatic step(input string tag, input logic [3:0] req, input logic [3:0] lck,
                      input logic [1:0] tr, input logic [2:0] bu, input logic rdy,
                      input logic [3:0] eg, input logic [1:0] em, input logic [1:0] ed,
                      input logic el);
    exp_t e;
    hbusreq = req;
    hlock   = lck;
    htrans  = tr;
    hburst  = bu;
    hready  = rdy;
    e.tag = tag;
    e.g   = eg;
    e.m   = em;
    e.d   = ed;
    e.l   = el;
    sb.push_back(e);
    @(posedge hclk);
    #1;
    e = sb.pop_front();
    check_outputs(e.tag, e.g, e.m, e.d, e.l);
  endtask

  initial begin
    hreset  = 1'b1;
    hbusreq = 4'b0000;
    hlock   = 4'b0000;
    htrans  = IDLE;
    hburst  = SINGLE;
    hready  = 1'b1;
    repeat (2) @(posedge hclk);
    #1;
    check_outputs("reset", 4'b0001, 2'd0, 2'd0, 1'b0);
    hreset = 1'b0;

    // 1: parked on the default master with no requests
    for (int i = 0; i < 10; i++)
      step("t1_park", 4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b0);

    // 2: M1/M2 alternate with SINGLE transfers
    step("t2_a", 4'b0110, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0010, 2'd0, 2'd0, 1'b0);
    step("t2_b", 4'b0110, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0010, 2'd1, 2'd0, 1'b0);
    step("t2_c", 4'b0110, 4'b0000, NONSEQ, SINGLE, 1'b1, 4'b0100, 2'd1, 2'd1, 1'b0);
    step("t2_d", 4'b0110, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0100, 2'd2, 2'd1, 1'b0);
    step("t2_e", 4'b0110, 4'b0000, NONSEQ, SINGLE, 1'b1, 4'b0010, 2'd2, 2'd2, 1'b0);
    step("t2_f", 4'b0110, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0010, 2'd1, 2'd2, 1'b0);

    // 3: M1 INCR8 with two BUSY cycles, everyone requesting
    step("t3_ns", 4'b1111, 4'b0000, NONSEQ, INCR8, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b0);
    for (int i = 0; i < 3; i++)
      step("t3_seq_a", 4'b1111, 4'b0000, SEQ, INCR8, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b0);
    for (int i = 0; i < 2; i++)
      step("t3_busy", 4'b1111, 4'b0000, BUSY, INCR8, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b0);
    for (int i = 0; i < 3; i++)
      step("t3_seq_b", 4'b1111, 4'b0000, SEQ, INCR8, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b0);
    step("t3_last", 4'b1111, 4'b0000, SEQ,  INCR8,  1'b1, 4'b0100, 2'd1, 2'd1, 1'b0);
    step("t3_hand", 4'b1111, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0100, 2'd2, 2'd1, 1'b0);

    // 4: M2 locked sequence of three SINGLE transfers
    step("t4_lk1",  4'b1111, 4'b0100, NONSEQ, SINGLE, 1'b1, 4'b0100, 2'd2, 2'd2, 1'b1);
    step("t4_lk2",  4'b1111, 4'b0100, NONSEQ, SINGLE, 1'b1, 4'b0100, 2'd2, 2'd2, 1'b1);
    step("t4_lk3",  4'b1111, 4'b0100, NONSEQ, SINGLE, 1'b1, 4'b0100, 2'd2, 2'd2, 1'b1);
    step("t4_rel",  4'b1111, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b1000, 2'd2, 2'd2, 1'b0);
    step("t4_hand", 4'b1111, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b1000, 2'd3, 2'd2, 1'b0);

    // 5: wait states during a handover freeze everything
    step("t5_ns", 4'b1111, 4'b0000, NONSEQ, SINGLE, 1'b1, 4'b0001, 2'd3, 2'd3, 1'b0);
    for (int i = 0; i < 5; i++)
      step("t5_wait", 4'b1111, 4'b0000, IDLE, SINGLE, 1'b0, 4'b0001, 2'd3, 2'd3, 1'b0);
    step("t5_hand", 4'b1111, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0001, 2'd0, 2'd3, 1'b0);

    // 6: async reset in the middle of an M1 INCR16; M1 drops its request mid-burst
    step("t6_arb",  4'b0010, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0010, 2'd0, 2'd0, 1'b0);
    step("t6_hand", 4'b0010, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0010, 2'd1, 2'd0, 1'b0);
    step("t6_ns",   4'b0010, 4'b0000, NONSEQ, INCR16, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b0);
    step("t6_s2",   4'b0100, 4'b0000, SEQ,    INCR16, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b0);
    step("t6_s3",   4'b0100, 4'b0000, SEQ,    INCR16, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b0);
    #3;
    hreset = 1'b1;
    #1;
    check_outputs("t6_async", 4'b0001, 2'd0, 2'd0, 1'b0);
    @(posedge hclk);
    #1;
    check_outputs("t6_held", 4'b0001, 2'd0, 2'd0, 1'b0);
    hreset = 1'b0;
    // pointer back at the default master: M1 wins before M2 and M3
    step("t6_rr",    4'b1110, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0010, 2'd0, 2'd0, 1'b0);
    step("t6_rr_hd", 4'b1110, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0010, 2'd1, 2'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
